// File: rtl/xpmwrap_sdpram_rdarb.sv
// Round-robin read arbiter for port B of xpmwrap_sdpram. It issues one read per
// cycle and routes the returning doutb word back to whichever requester issued it.
module xpmwrap_sdpram_rdarb #(
  parameter int ADDR_WIDTH_B      = 6,
  parameter int READ_DATA_WIDTH_B = 32,
  parameter int READ_LATENCY_B    = 2
) (
  input  logic                         clkb,
  input  logic                         rstb,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [ADDR_WIDTH_B-1:0]      req0_addr,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [ADDR_WIDTH_B-1:0]      req1_addr,
  output logic                         rsp0_valid,
  output logic                         rsp1_valid,
  output logic [READ_DATA_WIDTH_B-1:0] rsp_data,
  output logic                         busy,
  output logic                         mem_enb,
  output logic [ADDR_WIDTH_B-1:0]      mem_addrb,
  output logic                         mem_regceb,
  input  logic [READ_DATA_WIDTH_B-1:0] mem_doutb
);
  localparam int L = READ_LATENCY_B;

  logic         prio;
  logic         gnt_any;
  logic         gnt_id;
  logic [L:1]   vld_pipe;
  logic [L:1]   id_pipe;

  // Requester 1 wins when it is the only one asking, or under contention when prio is 1.
  always_comb begin
    gnt_any = !rstb && (req0_valid || req1_valid);
    gnt_id  = (req0_valid && req1_valid) ? prio : req1_valid;
  end

  assign req0_ready = gnt_any && !gnt_id && req0_valid;
  assign req1_ready = gnt_any &&  gnt_id && req1_valid;
  assign mem_enb    = gnt_any;
  assign mem_addrb  = !gnt_any ? '0 : (gnt_id ? req1_addr : req0_addr);
  assign mem_regceb = 1'b1;

  always_ff @(posedge clkb) begin
    if (rstb) begin
      prio     <= 1'b0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      if (gnt_any) prio <= !gnt_id;
      vld_pipe[1] <= gnt_any;
      id_pipe[1]  <= gnt_id;
      for (int k = 2; k <= L; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  // While reset is held, the stages may still contain reads that are being discarded. Mask them.
  assign rsp0_valid = !rstb && vld_pipe[L] && !id_pipe[L];
  assign rsp1_valid = !rstb && vld_pipe[L] &&  id_pipe[L];
  assign rsp_data   = mem_doutb;
  assign busy       = !rstb && (|vld_pipe);
endmodule
